btn_ctrl_input: RTL and testbench

//  Input-side companion to the LED pattern blocks: conditions raw push-buttons into the
//  en/dir/rst controls those blocks consume. Synchronises, debounces on a prescaled sample

---
 rtl/btn_ctrl_pkg.sv | 32 +++
 rtl/btn_debounce_pulse.sv | 90 +++++++++
 rtl/btn_ctrl_input.sv | 114 +++++++++++
 tb/tb_btn_ctrl_input.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the push-button input conditioner.
// Button indices, button count and default timing parameters.

package btn_ctrl_pkg;

  localparam int NUM_BTN = 3;

  localparam int BTN_EN  = 0;
  localparam int BTN_DIR = 1;
  localparam int BTN_RST = 2;

  localparam int DEF_SAMPLE_DIV_W = 16;
  localparam int DEF_DB_DEPTH     = 4;
  localparam int DEF_LONG_TICKS   = 64;

  typedef enum logic [1:0] {
    BTN_IDX_EN  = 2'd0,
    BTN_IDX_DIR = 2'd1,
    BTN_IDX_RST = 2'd2
  } btn_idx_e;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// One button lane: 2-flop sync, tick-sampled debounce, armed edge accept, 1-clk pulse.
// Ports: clk, rst (sync, active-high), tick_i, btn_i -> stable_o, press_o, pulse_o.

module btn_debounce_pulse
  import btn_ctrl_pkg::*;
#(
  parameter int DB_DEPTH = DEF_DB_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o,
  output logic pulse_o
);

  logic                s1_q;
  logic                s2_q;
  logic [DB_DEPTH-1:0] db_q;
  logic [DB_DEPTH-1:0] db_d;
  logic                stable_q;
  logic                stable_d;
  logic                prev_q;
  logic                armed_q;
  logic                armed_d;
  logic                pulse_q;
  logic                all1;
  logic                all0;
  logic                press;

  always_comb begin
    db_d = db_q;
    if (tick_i) begin
      db_d = {db_q[DB_DEPTH-2:0], s2_q};
    end
  end

  assign all1 = &db_d;
  assign all0 = ~|db_d;

  always_comb begin
    stable_d = stable_q;
    if (tick_i && all1) begin
      stable_d = 1'b1;
    end else if (tick_i && all0) begin
      stable_d = 1'b0;
    end
  end

  // Accept only the first cycle of a debounced rise, and only once
  // the lane has actually seen a debounced release since reset.
  assign press = stable_q & ~prev_q & armed_q;

  // Arming needs an observed all-zero history, so a button held
  // through reset stays disarmed until it is really released.
  always_comb begin
    armed_d = armed_q;
    if (press) begin
      armed_d = 1'b0;
    end else if (tick_i && all0) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      armed_q  <= armed_d;
      pulse_q  <= press;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press;
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/btn_ctrl_input.sv
// Push-button conditioner: prescaled sample tick, three debounce lanes, en/dir toggles.
// Ports: clk, rst (sync, active-high), btn_en_i, btn_dir_i, btn_rst_i ->
//   en, dir, en_pulse, dir_pulse, rst_req. Option macro BTN_LONGPRESS_EN adds long-press reset.

module btn_ctrl_input
  import btn_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV_W = DEF_SAMPLE_DIV_W,
  parameter int DB_DEPTH     = DEF_DB_DEPTH,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en_i,
  input  logic btn_dir_i,
  input  logic btn_rst_i,
  output logic en,
  output logic dir,
  output logic en_pulse,
  output logic dir_pulse,
  output logic rst_req
);

  logic [SAMPLE_DIV_W-1:0] div_q;
  logic                    tick;
  logic [NUM_BTN-1:0]      btn_raw;
  logic [NUM_BTN-1:0]      stable;
  logic [NUM_BTN-1:0]      press;
  logic [NUM_BTN-1:0]      pulse;
  logic                    en_q;
  logic                    dir_q;
  logic                    long_req;
  logic                    unused_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + SAMPLE_DIV_W'(1);
    end
  end

  assign tick = &div_q;

  always_comb begin
    btn_raw          = '0;
    btn_raw[BTN_EN]  = btn_en_i;
    btn_raw[BTN_DIR] = btn_dir_i;
    btn_raw[BTN_RST] = btn_rst_i;
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_debounce_pulse #(
      .DB_DEPTH (DB_DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .btn_i    (btn_raw[g]),
      .stable_o (stable[g]),
      .press_o  (press[g]),
      .pulse_o  (pulse[g])
    );
  end

  // Toggle on the accept cycle so the level flips on the
  // same edge that raises the matching pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      en_q  <= en_q ^ press[BTN_EN];
      dir_q <= dir_q ^ press[BTN_DIR];
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int LW = cnt_w(LONG_TICKS);

  logic [LW-1:0] long_cnt_q;
  logic          long_q;

  // Counts ticks of continuous en hold; fires once when the
  // count lands on LONG_TICKS, then sits saturated until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!stable[BTN_EN]) begin
        long_cnt_q <= '0;
      end else if (tick && (long_cnt_q != LW'(LONG_TICKS))) begin
        long_cnt_q <= long_cnt_q + LW'(1);
        long_q     <= (long_cnt_q == LW'(LONG_TICKS - 1));
      end
    end
  end

  assign long_req = long_q;
`else
  assign long_req = 1'b0;
`endif

  assign unused_sig = ^{stable, press[BTN_RST], (LONG_TICKS > 0)};

  assign en        = en_q;
  assign dir       = dir_q;
  assign en_pulse  = pulse[BTN_EN];
  assign dir_pulse = pulse[BTN_DIR];
  assign rst_req   = pulse[BTN_RST] | long_req;

endmodule

// File: tb/tb_btn_ctrl_input.sv
// Bench for btn_ctrl_input: directed scenarios plus random button traffic.
// Outputs are compared every cycle against a run-length behavioural model.

module tb_btn_ctrl_input;

  localparam int SDW  = 2;
  localparam int DB   = 3;
  localparam int LT   = 5;
  localparam int TPER = 1 << SDW;
`ifdef BTN_LONGPRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_en_i;
  logic btn_dir_i;
  logic btn_rst_i;
  logic en;
  logic dir;
  logic en_pulse;
  logic dir_pulse;
  logic rst_req;

  btn_ctrl_input #(
    .SAMPLE_DIV_W (SDW),
    .DB_DEPTH     (DB),
    .LONG_TICKS   (LT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_en_i  (btn_en_i),
    .btn_dir_i (btn_dir_i),
    .btn_rst_i (btn_rst_i),
    .en        (en),
    .dir       (dir),
    .en_pulse  (en_pulse),
    .dir_pulse (dir_pulse),
    .rst_req   (rst_req)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int n_en;
  int n_dir;
  int n_rst;
  int n_both;
  int first_en;

  // Model: per button, a run-length view of the sampled history.
  logic [2:0] m_s1, m_s2, m_rv, m_st, m_arm, m_pend, m_pulse;
  int         m_rl [3];
  logic       m_en, m_dir, m_long;
  int         m_cyc;
  int         m_lcnt;

  task automatic model_edge();
    logic [2:0] raw;
    bit         tk;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_rv = '0; m_st = '0;
      m_arm = '0; m_pend = '0; m_pulse = '0;
      for (int b = 0; b < 3; b++) m_rl[b] = DB;
      m_en = 0; m_dir = 0; m_long = 0;
      m_cyc = 0; m_lcnt = 0;
    end else begin
      raw = {btn_rst_i, btn_dir_i, btn_en_i};
      tk = (m_cyc % TPER) == (TPER - 1);
      m_cyc++;
      m_pulse = m_pend;
      m_arm = m_arm & ~m_pend;
      m_pend = '0;
      if (m_pulse[0]) m_en = !m_en;
      if (m_pulse[1]) m_dir = !m_dir;
      m_long = 0;
      if (!m_st[0]) m_lcnt = 0;
      else if (tk && m_lcnt < LT) begin
        m_lcnt++;
        if (m_lcnt == LT) m_long = 1;
      end
      if (tk) begin
        for (int b = 0; b < 3; b++) begin
          if (m_s2[b] == m_rv[b]) begin
            if (m_rl[b] < 1000) m_rl[b]++;
          end else begin
            m_rv[b] = m_s2[b];
            m_rl[b] = 1;
          end
          if (m_rl[b] >= DB) begin
            if (m_rv[b] && !m_st[b] && m_arm[b]) m_pend[b] = 1;
            m_st[b] = m_rv[b];
            if (!m_rv[b]) m_arm[b] = 1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic step();
    logic [4:0] obs, exp;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    obs = {en, dir, en_pulse, dir_pulse, rst_req};
    exp = {m_en, m_dir, m_pulse[0], m_pulse[1],
           m_pulse[2] | (LONG_ON & m_long)};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL cyc%0d outs{en,dir,enp,dirp,rreq} observed=%b expected=%b",
             cyc, obs, exp);
    end
    if (en_pulse === 1'b1) begin
      n_en++;
      if (first_en < 0) first_en = cyc;
    end
    if (dir_pulse === 1'b1) n_dir++;
    if (rst_req === 1'b1) n_rst++;
    if (en_pulse === 1'b1 && dir_pulse === 1'b1) n_both++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_en = 0; n_dir = 0; n_rst = 0; n_both = 0; first_en = -1;
  endtask

  task automatic reset_dut();
    btn_en_i = 0; btn_dir_i = 0; btn_rst_i = 0;
    rst = 1;
    run(2);
    rst = 0;
    run(10);
  endtask

  initial begin
    int t0;
    int lat;
    rst = 1; btn_en_i = 0; btn_dir_i = 0; btn_rst_i = 0;
    clr();
    run(3);
    chk("reset_outs", int'({en, dir, en_pulse, dir_pulse, rst_req}), 0);
    rst = 0;
    run(10);

    // clean en press
    clr();
    t0 = cyc;
    btn_en_i = 1;
    run(40);
    lat = first_en - t0;
    chk("clean_en_pulses", n_en, 1);
    chk("clean_en_level", int'(en), 1);
    chk("clean_en_latency_ok", int'(lat >= 12 && lat <= 15), 1);
    btn_en_i = 0;
    run(20);

    // bounce on dir
    clr();
    for (int i = 0; i < 6; i++) begin
      btn_dir_i = ~btn_dir_i;
      run(5);
    end
    btn_dir_i = 0;
    run(20);
    chk("bounce_dir_pulses", n_dir, 0);
    chk("bounce_dir_level", int'(dir), 0);

    // simultaneous en + dir from fresh state
    reset_dut();
    clr();
    btn_en_i = 1; btn_dir_i = 1;
    run(30);
    chk("simul_same_cycle", n_both, 1);
    chk("simul_en", int'(en), 1);
    chk("simul_dir", int'(dir), 1);
    btn_en_i = 0; btn_dir_i = 0;
    run(20);

    // rst button held across reset release
    btn_rst_i = 1;
    rst = 1;
    run(3);
    rst = 0;
    clr();
    run(30);
    chk("held_rst_no_req", n_rst, 0);
    btn_rst_i = 0;
    run(20);
    btn_rst_i = 1;
    run(20);
    chk("repress_rst_req", n_rst, 1);
    btn_rst_i = 0;
    run(20);

    // reset mid-debounce
    reset_dut();
    clr();
    btn_en_i = 1;
    run(8);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_outs", int'({en, dir, en_pulse, dir_pulse, rst_req}), 0);
    run(40);
    chk("midrst_no_pulse", n_en, 0);
    btn_en_i = 0;
    run(20);
    btn_en_i = 1;
    run(20);
    chk("midrst_repress", n_en, 1);
    chk("midrst_en", int'(en), 1);
    btn_en_i = 0;
    run(20);

    // long hold
    reset_dut();
    clr();
    btn_en_i = 1;
    run(60);
    chk("long_en_pulse", n_en, 1);
    chk("long_rst_req", n_rst, LONG_ON ? 1 : 0);
    btn_en_i = 0;
    run(30);
    chk("long_no_repeat", n_rst, LONG_ON ? 1 : 0);

    // random traffic
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) btn_en_i = ~btn_en_i;
      if ($urandom_range(0, 9) == 0) btn_dir_i = ~btn_dir_i;
      if ($urandom_range(0, 9) == 0) btn_rst_i = ~btn_rst_i;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
